// File: rtl/alu_wb_stage.sv
// Writeback stage behind the 128-bit WideWord ALU: captures result/rd/byte-mask and queues up to two writes for the register file.
// Latency: a result accepted at edge N is presented on wb_* after edge N (1 cycle); there is no combinational pass-through.
// Backpressure: in_ready = (occupancy < 2) comes from registered state only; a register-file stall holds entries and never drops one.
// Optional forwarding search across the held entries is enabled by defining ALU_WB_FWD_EN.
module alu_wb_stage #(
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:127]    in_result,
    input  logic [0:AW-1]   in_rd,
    input  logic [0:2]      in_ppp,
    input  logic [0:1]      in_ww,
    input  logic            in_wen,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [0:127]    wb_data,
    output logic [0:AW-1]   wb_addr,
    output logic [0:15]     wb_mask,
    output logic [0:1]      occupancy
`ifdef ALU_WB_FWD_EN
    ,
    input  logic [0:AW-1]   fwd_rd,
    output logic            fwd_hit,
    output logic            fwd_partial,
    output logic [0:127]    fwd_data
`endif
);

    // One buffered register-file write; the byte mask is resolved at capture time.
    typedef struct packed {
        logic [0:127]  data;
        logic [0:AW-1] rd;
        logic [0:15]   mask;
    } entry_t;

    // Only a 2-entry queue is supported; FULL is the count at which input stalls.
    localparam logic [0:1] FULL = 2'(DEPTH);

    // Byte b belongs to element b >> ww (element 0 is the most significant);
    // the last element index is 15 >> ww. ppp 111 yields an empty mask.
    function automatic logic [0:15] make_mask(input logic [0:2] ppp, input logic [0:1] ww);
        logic [0:15] m;
        logic [3:0]  elem;
        logic [3:0]  last_elem;
        m         = '0;
        last_elem = 4'd15 >> ww;
        for (int i = 0; i < 16; i++) begin
            elem = 4'(i) >> ww;
            case (ppp)
                3'b000:  m[i] = 1'b1;
                3'b001:  m[i] = (i < 8);
                3'b010:  m[i] = (i >= 8);
                3'b011:  m[i] = ~elem[0];
                3'b100:  m[i] = elem[0];
                3'b101:  m[i] = (elem == 4'd0);
                3'b110:  m[i] = (elem == last_elem);
                default: m[i] = 1'b0;
            endcase
        end
        return m;
    endfunction

    logic [0:1] count_q;
    entry_t     head_q;
    entry_t     tail_q;
    entry_t     new_ent;
    logic       push_fire;
    logic       store;
    logic       pop;

    assign in_ready  = (count_q != FULL);
    assign wb_valid  = (count_q != 2'd0);
    assign occupancy = count_q;

    // A completed input handshake only occupies a slot when it really writes a register.
    assign push_fire = in_valid & in_ready & ~flush;
    assign store     = push_fire & in_wen & (in_ppp != 3'b111);
    assign pop       = wb_valid & wb_ready;

    assign new_ent.data = in_result;
    assign new_ent.rd   = in_rd;
    assign new_ent.mask = make_mask(in_ppp, in_ww);

    // Queue update: head_q is always the oldest entry, tail_q the second one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            // The head pop in this cycle still completes; everything left is discarded.
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (store) begin
                        head_q  <= new_ent;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && store) begin
                        head_q <= new_ent;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end else if (store) begin
                        tail_q  <= new_ent;
                        count_q <= 2'd2;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Head presentation; idle outputs are held at zero.
    always_comb begin
        wb_data = '0;
        wb_addr = '0;
        wb_mask = '0;
        if (wb_valid) begin
            wb_data = head_q.data;
            wb_addr = head_q.rd;
            wb_mask = head_q.mask;
        end
    end

`ifdef ALU_WB_FWD_EN
    // Youngest matching entry wins; a partial-mask winner reports partial so the hazard unit stalls.
    always_comb begin
        entry_t win;
        logic   found;
        win         = '0;
        found       = 1'b0;
        fwd_hit     = 1'b0;
        fwd_partial = 1'b0;
        fwd_data    = '0;
        if ((count_q == 2'd2) && (tail_q.rd == fwd_rd)) begin
            win   = tail_q;
            found = 1'b1;
        end else if ((count_q != 2'd0) && (head_q.rd == fwd_rd)) begin
            win   = head_q;
            found = 1'b1;
        end
        if (found) begin
            if (win.mask == 16'hFFFF) begin
                fwd_hit  = 1'b1;
                fwd_data = win.data;
            end else begin
                fwd_partial = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: a queue-based reference of pending writes, compared against the DUT every cycle.
// Latency: expectations enter the queue at the accepting edge and are checked from the following negedge.
// Backpressure: wb_ready and flush are driven directed and randomly; the reference decides acceptance from its own queue size.
module tb_alu_wb_stage;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [0:127]  in_result;
    logic [0:4]    in_rd;
    logic [0:2]    in_ppp;
    logic [0:1]    in_ww;
    logic          in_wen;
    logic          flush;
    logic          wb_valid;
    logic          wb_ready;
    logic [0:127]  wb_data;
    logic [0:4]    wb_addr;
    logic [0:15]   wb_mask;
    logic [0:1]    occupancy;
`ifdef ALU_WB_FWD_EN
    logic [0:4]    fwd_rd;
    logic          fwd_hit;
    logic          fwd_partial;
    logic [0:127]  fwd_data;
`endif

    alu_wb_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_rd     (in_rd),
        .in_ppp    (in_ppp),
        .in_ww     (in_ww),
        .in_wen    (in_wen),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_mask   (wb_mask),
        .occupancy (occupancy)
`ifdef ALU_WB_FWD_EN
        ,
        .fwd_rd      (fwd_rd),
        .fwd_hit     (fwd_hit),
        .fwd_partial (fwd_partial),
        .fwd_data    (fwd_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [0:127] d;
        logic [0:4]   rd;
        logic [0:15]  m;
    } ent_t;

    ent_t         exp_q[$];
    logic [0:15]  exp_mask;
    int           vectors;
    int           miscompares;

    // Reference mask from the element rules: element size E bytes, N = 16/E elements, element 0 first.
    function automatic logic [0:15] ref_mask(input logic [0:2] ppp, input logic [0:1] ww);
        logic [0:15] m;
        int esz, n, e;
        esz = 1 << ww;
        n   = 16 / esz;
        m   = '0;
        for (int b = 0; b < 16; b++) begin
            e = b / esz;
            case (ppp)
                3'd0:    m[b] = 1'b1;
                3'd1:    m[b] = (b < 8);
                3'd2:    m[b] = (b >= 8);
                3'd3:    m[b] = (e % 2 == 0);
                3'd4:    m[b] = (e % 2 == 1);
                3'd5:    m[b] = (e == 0);
                3'd6:    m[b] = (e == n - 1);
                default: m[b] = 1'b0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference queue: pop completes first, flush discards the rest, then an accepted write is appended.
    logic ref_rdy, ref_pop, ref_store;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            ref_rdy   = (exp_q.size() < 2);
            ref_pop   = (exp_q.size() > 0) && wb_ready;
            ref_store = in_valid && ref_rdy && !flush && in_wen && (in_ppp != 3'b111);
            if (ref_pop) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            if (ref_store) exp_q.push_back('{in_result, in_rd, exp_mask});
        end
    end

    // Monitor: mid-cycle comparison of status and head write against the reference queue.
    logic          m_vld, m_rdy;
    logic [1:0]    m_occ;
    logic [0:127]  m_d;
    logic [0:4]    m_rd;
    logic [0:15]   m_m;
    always @(negedge clk) begin
        m_vld = (exp_q.size() != 0);
        m_rdy = (exp_q.size() < 2);
        m_occ = 2'(exp_q.size());
        m_d   = m_vld ? exp_q[0].d  : '0;
        m_rd  = m_vld ? exp_q[0].rd : '0;
        m_m   = m_vld ? exp_q[0].m  : '0;
        vectors++;
        if ({in_ready, wb_valid, occupancy} !== {m_rdy, m_vld, m_occ}) begin
            miscompares++;
            $display("FAIL status t=%0t got rdy=%b vld=%b occ=%0d exp rdy=%b vld=%b occ=%0d",
                     $time, in_ready, wb_valid, occupancy, m_rdy, m_vld, m_occ);
        end
        vectors++;
        if ({wb_data, wb_addr, wb_mask} !== {m_d, m_rd, m_m}) begin
            miscompares++;
            $display("FAIL head t=%0t got data=%h addr=%0d mask=%h exp data=%h addr=%0d mask=%h",
                     $time, wb_data, wb_addr, wb_mask, m_d, m_rd, m_m);
        end
`ifdef ALU_WB_FWD_EN
        begin
            logic          f_hit, f_part, found;
            logic [0:127]  f_d;
            f_hit = 1'b0; f_part = 1'b0; f_d = '0; found = 1'b0;
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (!found && exp_q[k].rd == fwd_rd) begin
                    found = 1'b1;
                    if (exp_q[k].m == 16'hFFFF) begin
                        f_hit = 1'b1;
                        f_d   = exp_q[k].d;
                    end else begin
                        f_part = 1'b1;
                    end
                end
            end
            vectors++;
            if ({fwd_hit, fwd_partial, fwd_data} !== {f_hit, f_part, f_d}) begin
                miscompares++;
                $display("FAIL fwd t=%0t got hit=%b part=%b data=%h exp hit=%b part=%b data=%h",
                         $time, fwd_hit, fwd_partial, fwd_data, f_hit, f_part, f_d);
            end
        end
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one result for a single cycle; em is the byte mask expected if it is stored.
    task automatic push(input logic [0:4] rd, input logic [0:2] ppp, input logic [0:1] ww,
                        input logic [0:15] em);
        in_valid  = 1'b1;
        in_wen    = 1'b1;
        in_rd     = rd;
        in_ppp    = ppp;
        in_ww     = ww;
        in_result = rand128();
        exp_mask  = em;
        cyc();
        in_valid  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_wen    = 1'b1;
        in_rd     = 5'd7;
        in_ppp    = 3'b000;
        in_ww     = 2'b00;
        in_result = rand128();
        exp_mask  = 16'hFFFF;
        flush     = 1'b0;
        wb_ready  = 1'b0;
`ifdef ALU_WB_FWD_EN
        fwd_rd    = 5'd4;
`endif
        // Reset held with in_valid high: nothing may be captured.
        repeat (3) cyc();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        cyc();

        // First write: rd=3, w8, even elements.
        push(5'd3, 3'b011, 2'b00, 16'hAAAA);
        cyc();
        wb_ready = 1'b1;
        cyc();

        // Mask sweep, back-to-back with the register file always ready.
        push(5'd1, 3'b011, 2'b01, 16'hCCCC);
        push(5'd2, 3'b100, 2'b10, 16'h0F0F);
        push(5'd5, 3'b101, 2'b11, 16'hFF00);
        push(5'd6, 3'b110, 2'b00, 16'h0001);
        push(5'd8, 3'b001, 2'b01, 16'hFF00);
        push(5'd9, 3'b010, 2'b10, 16'h00FF);
        push(5'd10, 3'b111, 2'b00, 16'h0000);
        push(5'd11, 3'b110, 2'b01, 16'h0003);
        push(5'd12, 3'b110, 2'b11, 16'h00FF);
        cyc();

        // Stall: three back-to-back results, only two fit; then drain in order.
        wb_ready = 1'b0;
        cyc();
        push(5'd13, 3'b000, 2'b00, 16'hFFFF);
        push(5'd14, 3'b011, 2'b00, 16'hAAAA);
        push(5'd15, 3'b100, 2'b00, 16'h5555);
        cyc();
        wb_ready = 1'b1;
        repeat (3) cyc();

        // occupancy 1: simultaneous push and pop keeps one entry, the new one.
        push(5'd16, 3'b000, 2'b10, 16'hFFFF);
        push(5'd17, 3'b101, 2'b10, 16'hF000);
        cyc();

        // occupancy 2 then flush with a pop and a push in the same cycle.
        wb_ready = 1'b0;
        push(5'd18, 3'b000, 2'b00, 16'hFFFF);
        push(5'd19, 3'b001, 2'b00, 16'hFF00);
        wb_ready  = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_rd     = 5'd20;
        in_ppp    = 3'b000;
        in_result = rand128();
        exp_mask  = 16'hFFFF;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc();

`ifdef ALU_WB_FWD_EN
        // Forwarding: older full write then newer partial write to rd 4.
        wb_ready = 1'b0;
        fwd_rd   = 5'd4;
        push(5'd4, 3'b000, 2'b00, 16'hFFFF);
        push(5'd4, 3'b001, 2'b00, 16'hFF00);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        push(5'd4, 3'b000, 2'b00, 16'hFFFF);
        cyc();
        wb_ready = 1'b1;
        cyc();
`endif

        // Randomized traffic with stalls, flushes and one asynchronous reset mid-stream.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_wen    = ($urandom % 8) != 0;
            in_rd     = 5'($urandom % 6);
            in_ppp    = 3'($urandom);
            in_ww     = 2'($urandom);
            in_result = rand128();
            exp_mask  = ref_mask(in_ppp, in_ww);
            wb_ready  = ($urandom % 3) != 0;
            flush     = ($urandom % 24) == 0;
`ifdef ALU_WB_FWD_EN
            fwd_rd    = 5'($urandom % 6);
`endif
            if (i == 300) reset_n = 1'b0;
            if (i == 302) reset_n = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
